dbus_wb_bridge: RTL and testbench
=================================

// Module: dbus_wb_bridge
// PURPOSE
//  Bridges the core data bus (dbus_*) to a Wishbone B4 classic single-access master port; sits directly downstream of the memory stage.
//  Registers each dbus request, runs one WB cycle, returns read data with a one-cycle ack pulse.
//  Holds dbus_busy while a transfer is outstanding.
//  Reports bus errors (and, optionally, timeouts) to the core.
// PARAMETERS
//  p_timeout   255            cycles in ACCESS before forced termination (only with DBUS_WB_TIMEOUT_EN); 1..65535
//  p_err_data  32'h0000_0000  value returned on dbus_rd_data for an errored/timed-out read
// PORTS
//  i_clk          in   1   global clock, rising edge
//  i_rst          in   1   reset: synchronous, active-high
//  dbus_addr      in   32  word-aligned byte address ([1:0] ignored)
//  dbus_be        in   4   byte enables
//  dbus_wr_en     in   1   write request
//  dbus_wr_data   in   32  write data, already lane-aligned
//  dbus_rd_en     in   1   read request
//  dbus_rd_data   out  32  read data, registered
//  dbus_busy      out  1   bridge cannot accept a request
//  dbus_ack       out  1   one-cycle transfer-complete pulse
//  o_bus_err      out  1   one-cycle pulse, coincident with dbus_ack, on WB error/timeout
//  o_wb_adr       out  30  WB word address = dbus_addr[31:2]
//  o_wb_dat       out  32  WB write data
//  o_wb_sel       out  4   WB byte select
//  o_wb_we        out  1   WB write enable
//  o_wb_cyc       out  1   WB cycle
//  o_wb_stb       out  1   WB strobe
//  i_wb_dat       in   32  WB read data
//  i_wb_ack       in   1   WB acknowledge
//  i_wb_err       in   1   WB error
// BEHAVIOUR
//  Reset (i_rst high at a clock edge): state=IDLE.
//   - Control/handshake outputs: cyc=stb=we=0, dbus_busy=0, dbus_ack=0, o_bus_err=0.
//   - Data outputs: dbus_rd_data=0, o_wb_adr/dat/sel=0.
//   - Reset mid-transfer abandons the WB cycle immediately (cyc drops the next cycle); no ack is issued.
//  FSM IDLE -> ACCESS -> IDLE, all outputs registered.
//  IDLE:
//   - dbus_busy=0.
//   - If (dbus_wr_en|dbus_rd_en) at an edge: latch adr/sel/dat; set we=dbus_wr_en; cyc=stb=1; go to ACCESS.
//   - wr_en and rd_en both high: treated as a write.
//  ACCESS:
//   - dbus_busy=1; cyc/stb/adr/sel/dat/we held stable.
//   - New dbus requests are ignored; the core must hold its request until dbus_ack.
//  Termination: an edge in ACCESS with i_wb_ack|i_wb_err:
//   - cyc=stb=0; dbus_ack=1 for exactly 1 cycle; return to IDLE.
//   - Read: dbus_rd_data <= i_wb_ack ? i_wb_dat : p_err_data. Write: dbus_rd_data unchanged.
//   - i_wb_err, or ack and err together: err wins; o_bus_err=1 with dbus_ack.
//  Latency, zero-wait-state slave: request sampled at edge 0, cyc/stb high after edge 0, ack sampled at edge 1, dbus_ack high after edge 1 (2 cycles).
//  Each slave wait state adds 1 cycle.
//  dbus_rd_data holds its value until the next completed read.
//  Back-to-back: the request is re-sampled in IDLE on the cycle dbus_ack is high.
//   - Minimum spacing of two transfers: 2 cycles each; no WB cycle merging.
//  dbus_ack and dbus_busy are never high together after termination (busy drops with ack).
//  WB acks arriving while IDLE are ignored.
// CONFIGURATION
//  DBUS_WB_TIMEOUT_EN defined:
//   - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle.
//   - Counter == p_timeout-1 with no ack/err: terminate as a WB error (cyc=0, dbus_ack=1, o_bus_err=1, read data=p_err_data).
//  DBUS_WB_TIMEOUT_EN undefined:
//   - No counter; ACCESS waits indefinitely.
//   - o_bus_err only reflects i_wb_err.
// TESTING
//  1. Read, 0 wait states, slave data 32'hCAFEF00D:
//     - cyc/stb 1 cycle, dbus_ack 2 cycles after the request edge.
//     - dbus_rd_data=32'hCAFEF00D; busy=1 only during ACCESS.
//  2. Write addr 32'h0000_1006, be 4'b1100, data 32'hBEEF_0000, 3 wait states:
//     - o_wb_adr=30'h401, sel=4'b1100, we=1, stable 4 cycles.
//     - dbus_ack after the 4th cycle; rd_data unchanged.
//  3. Read with i_wb_err:
//     - dbus_ack=o_bus_err=1 in the same cycle; dbus_rd_data=p_err_data.
//  4. Back-to-back write then read, request held high:
//     - Two distinct WB cycles, cyc low exactly 1 cycle between them.
//     - Second dbus_ack 2 cycles after the first.
//  5. i_rst asserted during ACCESS:
//     - cyc/stb=0, busy=0, no dbus_ack; the next request completes normally.
//  6. DBUS_WB_TIMEOUT_EN, p_timeout=8, silent slave:
//     - Termination after 8 ACCESS cycles with o_bus_err=1, read data=p_err_data.
//     - Without the macro: still busy after 1000 cycles.

Source files
------------

// File: rtl/dbus_wb_bridge.sv
// dbus_wb_bridge: core dbus to Wishbone B4 classic single-access master; DBUS_WB_TIMEOUT_EN adds an ACCESS timeout
module dbus_wb_bridge #(
  parameter int          p_timeout  = 255,
  parameter logic [31:0] p_err_data = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] dbus_addr,
  input  logic [3:0]  dbus_be,
  input  logic        dbus_wr_en,
  input  logic [31:0] dbus_wr_data,
  input  logic        dbus_rd_en,
  output logic [31:0] dbus_rd_data,
  output logic        dbus_busy,
  output logic        dbus_ack,
  output logic        o_bus_err,
  output logic [29:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
  localparam logic [15:0] tmo_last = 16'(p_timeout - 1);
  state_t state_q, state_d;
  logic [29:0] adr_d;
  logic [31:0] dat_d, rd_d;
  logic [3:0] sel_d;
  logic we_d, ack_d, err_d, capture, term, fail, timeout;
  logic unused;
  assign unused = ^{dbus_addr[1:0], tmo_last};
  assign o_wb_cyc = state_q == ACCESS;
  assign o_wb_stb = state_q == ACCESS;
  assign dbus_busy = state_q == ACCESS;
`ifdef DBUS_WB_TIMEOUT_EN
  logic [15:0] cnt_q;
  // cycles spent in ACCESS, cleared while idle so it starts at zero on entry
  always_ff @(posedge i_clk)
    if (i_rst) cnt_q <= '0;
    else cnt_q <= state_q == IDLE ? 16'd0 : cnt_q + 16'd1;
  assign timeout = state_q == ACCESS && cnt_q == tmo_last && !(i_wb_ack || i_wb_err);
`else
  assign timeout = 1'b0;
`endif
  // next state and next registered outputs; errors and timeouts take precedence over ack
  always_comb begin
    fail    = i_wb_err | timeout;
    term    = state_q == ACCESS && (i_wb_ack || fail);
    capture = state_q == IDLE && (dbus_wr_en || dbus_rd_en);
    state_d = capture ? ACCESS : term ? IDLE : state_q;
    adr_d   = capture ? dbus_addr[31:2] : o_wb_adr;
    dat_d   = capture ? dbus_wr_data : o_wb_dat;
    sel_d   = capture ? dbus_be : o_wb_sel;
    we_d    = capture ? dbus_wr_en : o_wb_we;
    ack_d   = term;
    err_d   = term & fail;
    rd_d    = term && !o_wb_we ? (fail ? p_err_data : i_wb_dat) : dbus_rd_data;
  end
  // state and output registers; reset abandons any WB cycle without an ack
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q      <= IDLE;
      o_wb_adr     <= '0;
      o_wb_dat     <= '0;
      o_wb_sel     <= '0;
      o_wb_we      <= 1'b0;
      dbus_ack     <= 1'b0;
      o_bus_err    <= 1'b0;
      dbus_rd_data <= '0;
    end else begin
      state_q      <= state_d;
      o_wb_adr     <= adr_d;
      o_wb_dat     <= dat_d;
      o_wb_sel     <= sel_d;
      o_wb_we      <= we_d;
      dbus_ack     <= ack_d;
      o_bus_err    <= err_d;
      dbus_rd_data <= rd_d;
    end
endmodule

// File: tb/tb_dbus_wb_bridge.sv
// tb_dbus_wb_bridge: table-driven and directed checks of dbus_wb_bridge
module tb_dbus_wb_bridge;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic i_clk = 0, i_rst = 1;
  logic [31:0] dbus_addr = 0, dbus_wr_data = 0, i_wb_dat = 0;
  logic [3:0] dbus_be = 0;
  logic dbus_wr_en = 0, dbus_rd_en = 0, i_wb_ack = 0, i_wb_err = 0;
  logic [31:0] dbus_rd_data, o_wb_dat;
  logic [29:0] o_wb_adr;
  logic [3:0] o_wb_sel;
  logic dbus_busy, dbus_ack, o_bus_err, o_wb_we, o_wb_cyc, o_wb_stb;
  int checks = 0, errors = 0;
  dbus_wb_bridge #(.p_timeout(8), .p_err_data(ERR)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wr_en(dbus_wr_en), .dbus_wr_data(dbus_wr_data), .dbus_rd_en(dbus_rd_en),
    .dbus_rd_data(dbus_rd_data), .dbus_busy(dbus_busy), .dbus_ack(dbus_ack),
    .o_bus_err(o_bus_err), .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_dat(i_wb_dat),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err));
  always #5 i_clk = ~i_clk;
  typedef struct {
    logic wr, rd;
    logic [31:0] addr;
    logic [3:0] be;
    logic [31:0] wdata;
    int waits;
    logic sack, serr;
    logic [31:0] sdata;
    logic [29:0] exp_adr;
    logic [31:0] exp_rd;
    logic exp_err;
  } vec_t;
  vec_t vec[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic run(input vec_t v);
    dbus_addr = v.addr; dbus_be = v.be; dbus_wr_data = v.wdata;
    dbus_wr_en = v.wr; dbus_rd_en = v.rd; i_wb_dat = v.sdata;
    step();
    chk("cyc", o_wb_cyc, 1); chk("stb", o_wb_stb, 1); chk("busy", dbus_busy, 1);
    chk("adr", o_wb_adr, v.exp_adr); chk("sel", o_wb_sel, v.be);
    chk("we", o_wb_we, v.wr); chk("dat", o_wb_dat, v.wdata); chk("ack_early", dbus_ack, 0);
    dbus_wr_en = 0; dbus_rd_en = 0; dbus_addr = ~v.addr; dbus_be = ~v.be; dbus_wr_data = ~v.wdata;
    for (int w = 0; w < v.waits; w++) begin
      step();
      chk("hold_cyc", o_wb_cyc, 1); chk("hold_ack", dbus_ack, 0);
      chk("hold_adr", o_wb_adr, v.exp_adr); chk("hold_sel", o_wb_sel, v.be);
      chk("hold_dat", o_wb_dat, v.wdata); chk("hold_we", o_wb_we, v.wr);
    end
    i_wb_ack = v.sack; i_wb_err = v.serr;
    step();
    i_wb_ack = 0; i_wb_err = 0;
    chk("ack", dbus_ack, 1); chk("bus_err", o_bus_err, v.exp_err);
    chk("busy_drop", dbus_busy, 0); chk("cyc_drop", o_wb_cyc, 0); chk("rd_data", dbus_rd_data, v.exp_rd);
    step();
    chk("ack_pulse", dbus_ack, 0); chk("err_pulse", o_bus_err, 0); chk("rd_hold", dbus_rd_data, v.exp_rd);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    vec[0] = '{0, 1, 32'h0000_0040, 4'hF, 32'h0, 0, 1, 0, 32'hCAFE_F00D, 30'h10, 32'hCAFE_F00D, 0};
    vec[1] = '{1, 0, 32'h0000_1006, 4'hC, 32'hBEEF_0000, 3, 1, 0, 32'h1111_1111, 30'h401, 32'hCAFE_F00D, 0};
    vec[2] = '{0, 1, 32'h2000_0008, 4'hF, 32'h0, 1, 0, 1, 32'h2222_2222, 30'h0800_0002, ERR, 1};
    vec[3] = '{0, 1, 32'hFFFF_FFFC, 4'h3, 32'h0, 2, 1, 0, 32'h1234_5678, 30'h3FFF_FFFF, 32'h1234_5678, 0};
    vec[4] = '{1, 1, 32'h0000_0010, 4'h3, 32'h0000_A5A5, 0, 1, 1, 32'h3333_3333, 30'h4, 32'h1234_5678, 1};
    vec[5] = '{0, 1, 32'h0000_0020, 4'hF, 32'h0, 0, 1, 1, 32'h5555_5555, 30'h8, ERR, 1};
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_cyc", o_wb_cyc, 0); chk("rst_stb", o_wb_stb, 0); chk("rst_we", o_wb_we, 0);
    chk("rst_busy", dbus_busy, 0); chk("rst_ack", dbus_ack, 0); chk("rst_err", o_bus_err, 0);
    chk("rst_rd", dbus_rd_data, 0); chk("rst_adr", o_wb_adr, 0); chk("rst_dat", o_wb_dat, 0);
    chk("rst_sel", o_wb_sel, 0);
    i_rst = 0;
    i_wb_ack = 1; i_wb_dat = 32'hFFFF_0000;
    step();
    i_wb_ack = 0;
    chk("idle_ack_ign", dbus_ack, 0); chk("idle_cyc", o_wb_cyc, 0);
    step();
    chk("idle_ack_ign2", dbus_ack, 0); chk("idle_rd", dbus_rd_data, 0);
    for (int i = 0; i < 6; i++) run(vec[i]);
    dbus_addr = 32'h100; dbus_be = 4'hF; dbus_wr_data = 32'h1111_1111; dbus_wr_en = 1;
    step();
    chk("b2b_cyc1", o_wb_cyc, 1); chk("b2b_we1", o_wb_we, 1);
    i_wb_ack = 1;
    step();
    chk("b2b_ack1", dbus_ack, 1); chk("b2b_gap", o_wb_cyc, 0); chk("b2b_busy_gap", dbus_busy, 0);
    i_wb_ack = 0; dbus_wr_en = 0; dbus_rd_en = 1; dbus_addr = 32'h200; i_wb_dat = 32'h0000_0077;
    step();
    chk("b2b_cyc2", o_wb_cyc, 1); chk("b2b_we2", o_wb_we, 0); chk("b2b_adr2", o_wb_adr, 30'h80);
    chk("b2b_ack_gap", dbus_ack, 0);
    i_wb_ack = 1;
    step();
    chk("b2b_ack2", dbus_ack, 1); chk("b2b_rd2", dbus_rd_data, 32'h77);
    i_wb_ack = 0; dbus_rd_en = 0;
    step();
    chk("b2b_idle", o_wb_cyc, 0); chk("b2b_ack_end", dbus_ack, 0);
    dbus_rd_en = 1; dbus_addr = 32'h300;
    step();
    chk("mid_cyc", o_wb_cyc, 1);
    i_rst = 1; dbus_rd_en = 0;
    step();
    i_rst = 0;
    chk("mid_cyc0", o_wb_cyc, 0); chk("mid_stb0", o_wb_stb, 0); chk("mid_busy0", dbus_busy, 0);
    chk("mid_ack0", dbus_ack, 0);
    i_wb_ack = 1;
    step();
    i_wb_ack = 0;
    chk("mid_noack", dbus_ack, 0);
    run('{0, 1, 32'h0000_0044, 4'hF, 32'h0, 0, 1, 0, 32'h600D_D00D, 30'h11, 32'h600D_D00D, 0});
    dbus_rd_en = 1; dbus_addr = 32'h400;
    step();
    dbus_rd_en = 0;
`ifdef DBUS_WB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      step();
      chk("tmo_wait", dbus_ack, 0);
    end
    step();
    chk("tmo_ack", dbus_ack, 1); chk("tmo_err", o_bus_err, 1);
    chk("tmo_rd", dbus_rd_data, ERR); chk("tmo_cyc", o_wb_cyc, 0);
`else
    repeat (1000) step();
    chk("no_tmo_busy", dbus_busy, 1); chk("no_tmo_cyc", o_wb_cyc, 1); chk("no_tmo_ack", dbus_ack, 0);
    i_rst = 1;
    step();
    i_rst = 0;
    chk("no_tmo_rst", dbus_busy, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
